// File: rtl/nbuf_frame_ctrl.sv
// N-buffer frame controller: hands DRAM frame buffers to one writer and one reader,
// either latest-frame (drops/repeats frames) or lossless FIFO with back-pressure.
module nbuf_frame_ctrl #(
  parameter int NBUF = 3,
  parameter int IDXW = 3,
  parameter int SEQW = 8
) (
  input  logic            fclk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            mode,
  input  logic [31:0]     FRAME_BYTES,
  input  logic [31:0]     BUF_BASE,
  input  logic [31:0]     BUF_STRIDE,
  output logic            wr_frame_valid,
  input  logic            wr_frame_ready,
  output logic [31:0]     wr_BUF_ADDR,
  output logic [31:0]     wr_FRAME_BYTES,
  input  logic            wr_frame_done,
  output logic            rd_frame_valid,
  input  logic            rd_frame_ready,
  output logic [31:0]     rd_BUF_ADDR,
  output logic [31:0]     rd_FRAME_BYTES,
  input  logic            rd_frame_done,
  output logic            running,
  output logic [15:0]     drop_cnt,
  output logic [15:0]     repeat_cnt,
  output logic [15:0]     err_cnt,
  output logic [IDXW-1:0] debug_wr_idx,
  output logic [IDXW-1:0] debug_rd_idx
);
  localparam int AW = $clog2(NBUF);

  typedef enum logic [2:0] {
    B_FREE, B_OFFERED_W, B_WRITING, B_FULL, B_OFFERED_R, B_READING
  } buf_state_e;

  buf_state_e      buf_st [NBUF];
  logic [SEQW-1:0] stamp  [NBUF];
  logic [NBUF-1:0] rep;            // buffer went back to FULL after a read: next read offer is a repeat
  logic [SEQW-1:0] seq;
  logic            mode_r;
  logic [31:0]     base_r, stride_r;
  logic            wr_busy, rd_busy, wr_from_full;
  logic [AW-1:0]   wr_i, rd_i;

  logic            free_found, newer_full;
  logic [AW-1:0]   free_i, oldest_i, newest_i, wr_cand_i, rd_cand_i;
  logic [3:0]      full_cnt;
  logic [SEQW-1:0] age, rd_age, oldest_age, newest_age;
  logic            wr_offer, rd_offer, wr_drop, rd_rep, wr_stray, rd_stray;
  logic [1:0]      err_inc;

  assign debug_wr_idx = IDXW'(wr_i);
  assign debug_rd_idx = IDXW'(rd_i);

  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + 17'(inc);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Candidate selection; ages are wrapping distances from the sequence counter.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    free_found = 1'b0;
    free_i     = '0;
    full_cnt   = '0;
    oldest_i   = '0;
    newest_i   = '0;
    oldest_age = '0;
    newest_age = '0;
    age        = '0;
    newer_full = 1'b0;
    rd_age     = seq - stamp[rd_i];
    for (int i = NBUF - 1; i >= 0; i--) begin
      if (buf_st[i] == B_FREE) begin
        free_found = 1'b1;
        free_i     = AW'(i);
      end
    end
    for (int i = 0; i < NBUF; i++) begin
      if (buf_st[i] == B_FULL) begin
        age = seq - stamp[i];
        if (full_cnt == 4'd0 || age > oldest_age) begin
          oldest_age = age;
          oldest_i   = AW'(i);
        end
        if (full_cnt == 4'd0 || age < newest_age) begin
          newest_age = age;
          newest_i   = AW'(i);
        end
        if (age < rd_age) newer_full = 1'b1;
        full_cnt = full_cnt + 4'd1;
      end
    end
    wr_cand_i = free_found ? free_i : oldest_i;
    wr_drop   = !free_found;
    wr_offer  = running && !stop && !wr_frame_valid && !wr_busy &&
                (free_found || (!mode_r && full_cnt >= 4'd2));
    rd_cand_i = mode_r ? oldest_i : newest_i;
    rd_rep    = rep[rd_cand_i];
    rd_offer  = running && !stop && !rd_frame_valid && !rd_busy && (full_cnt != 4'd0);
    wr_stray  = wr_frame_done && !wr_busy;
    rd_stray  = rd_frame_done && !rd_busy;
    err_inc   = {1'b0, wr_stray} + {1'b0, rd_stray};
  end

  always_ff @(posedge fclk) begin
    // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
    if (rst || start) begin
      // NOTE: the buffer table is a few flops rather than a RAM, so it is reset with everything else.
      for (int i = 0; i < NBUF; i++) begin
        buf_st[i] <= B_FREE;
        stamp[i]  <= '0;
      end
      rep            <= '0;
      seq            <= '0;
      wr_frame_valid <= 1'b0;
      rd_frame_valid <= 1'b0;
      wr_BUF_ADDR    <= '0;
      rd_BUF_ADDR    <= '0;
      wr_i           <= '0;
      rd_i           <= '0;
      wr_busy        <= 1'b0;
      rd_busy        <= 1'b0;
      wr_from_full   <= 1'b0;
      if (rst) begin
        mode_r         <= 1'b0;
        base_r         <= '0;
        stride_r       <= '0;
        wr_FRAME_BYTES <= '0;
        rd_FRAME_BYTES <= '0;
        running        <= 1'b0;
        drop_cnt       <= '0;
        repeat_cnt     <= '0;
        err_cnt        <= '0;
      end else begin
        mode_r         <= mode;
        base_r         <= BUF_BASE;
        stride_r       <= BUF_STRIDE;
        wr_FRAME_BYTES <= FRAME_BYTES;
        rd_FRAME_BYTES <= FRAME_BYTES;
        running        <= 1'b1;
      end
    end else begin
      if (stop) running <= 1'b0;

      if (wr_frame_valid && wr_frame_ready) begin
        buf_st[wr_i]   <= B_WRITING;
        wr_frame_valid <= 1'b0;
        wr_busy        <= 1'b1;
      end else if (wr_frame_valid && stop) begin
        buf_st[wr_i]   <= wr_from_full ? B_FULL : B_FREE;
        wr_frame_valid <= 1'b0;
      end
      if (wr_frame_done && wr_busy) begin
        buf_st[wr_i] <= B_FULL;
        stamp[wr_i]  <= seq;
        seq          <= seq + SEQW'(1);
        wr_busy      <= 1'b0;
      end
      if (wr_offer) begin
        buf_st[wr_cand_i] <= B_OFFERED_W;
        rep[wr_cand_i]    <= 1'b0;
        wr_frame_valid    <= 1'b1;
        wr_BUF_ADDR       <= base_r + 32'(wr_cand_i) * stride_r;
        wr_i              <= wr_cand_i;
        wr_from_full      <= wr_drop;
      end

      if (rd_frame_valid && rd_frame_ready) begin
        buf_st[rd_i]   <= B_READING;
        rd_frame_valid <= 1'b0;
        rd_busy        <= 1'b1;
      end else if (rd_frame_valid && stop) begin
        buf_st[rd_i]   <= B_FULL;
        rd_frame_valid <= 1'b0;
      end
      // Latest mode keeps the last frame on screen until something newer exists.
      if (rd_frame_done && rd_busy) begin
        if (mode_r || newer_full) begin
          buf_st[rd_i] <= B_FREE;
        end else begin
          buf_st[rd_i] <= B_FULL;
          rep[rd_i]    <= 1'b1;
        end
        rd_busy <= 1'b0;
      end
      if (rd_offer) begin
        buf_st[rd_cand_i] <= B_OFFERED_R;
        rep[rd_cand_i]    <= 1'b0;
        rd_frame_valid    <= 1'b1;
        rd_BUF_ADDR       <= base_r + 32'(rd_cand_i) * stride_r;
        rd_i              <= rd_cand_i;
      end

      drop_cnt   <= sat_add(drop_cnt, {1'b0, wr_offer && wr_drop});
      repeat_cnt <= sat_add(repeat_cnt, {1'b0, rd_offer && rd_rep});
      err_cnt    <= sat_add(err_cnt, err_inc);
    end
  end

endmodule
